// File: rtl/axis_host_ingress_gate.sv
// axis_host_ingress_gate: per-packet admission gate on the host-to-user
// ingress stream. It forwards packets whose TID is on the allow-list, cuts
// packets longer than the beat bound, and silently drops everything else.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for the first beat; config snapshot taken on that beat
// PASS  | forwarding the body of an admitted packet
// DROP  | swallowing the rest of a disallowed packet
// DRAIN | swallowing the tail of a packet cut at the beat limit
module axis_host_ingress_gate #(
  parameter int DATA_BITS = 512,
  parameter int TID_BITS  = 6,
  parameter int LEN_BITS  = 16,
  parameter int CNT_BITS  = 32
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [DATA_BITS-1:0]   s_axis_tdata,
  input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
  input  logic [TID_BITS-1:0]    s_axis_tid,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [DATA_BITS-1:0]   m_axis_tdata,
  output logic [DATA_BITS/8-1:0] m_axis_tkeep,
  output logic [TID_BITS-1:0]    m_axis_tid,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  input  logic                   cfg_en,
  input  logic [2**TID_BITS-1:0] cfg_tid_allow,
  input  logic [LEN_BITS-1:0]    cfg_max_beats,
  output logic [CNT_BITS-1:0]    stat_fwd_pkts,
  output logic [CNT_BITS-1:0]    stat_drop_pkts,
  output logic [CNT_BITS-1:0]    stat_trunc_pkts,
  output logic                   busy
);

  localparam int KEEP_BITS = DATA_BITS / 8;
  localparam int BEAT_BITS = DATA_BITS + KEEP_BITS + TID_BITS + 1;

  typedef enum logic [1:0] {IDLE, PASS, DROP, DRAIN} state_t;

  state_t               state, state_nxt;
  logic [LEN_BITS-1:0]  beat_cnt, beat_cnt_nxt;
  logic [LEN_BITS-1:0]  lim_q, lim_nxt;
  logic [LEN_BITS:0]    cnt_inc;
  logic                 s_fire, pop, push, push_last;
  logic                 inc_fwd, inc_drop, inc_trunc;
  logic [BEAT_BITS-1:0] buf_mem [2];
  logic                 wr_ptr, rd_ptr;
  logic [1:0]           buf_cnt, buf_cnt_nxt;
  logic                 rdy_q;

  // Discarding states never back-pressure; otherwise ready is the registered not-full flag.
  assign s_axis_tready = (state == DROP || state == DRAIN) ? 1'b1 : rdy_q;
  assign s_fire        = s_axis_tvalid && s_axis_tready;
  assign m_axis_tvalid = (buf_cnt != 2'd0);
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tid, m_axis_tlast} = buf_mem[rd_ptr];
  assign busy          = (state != IDLE) || (buf_cnt != 2'd0);
  // One extra bit so the limit compare cannot wrap when the counter is all-ones.
  assign cnt_inc       = {1'b0, beat_cnt} + {{LEN_BITS{1'b0}}, 1'b1};

  // Next-state, push decision and statistics strobes.
  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    lim_nxt      = lim_q;
    push         = 1'b0;
    push_last    = s_axis_tlast;
    inc_fwd      = 1'b0;
    inc_drop     = 1'b0;
    inc_trunc    = 1'b0;
    case (state)
      IDLE: begin
        if (s_fire) begin
          if (!cfg_en || cfg_tid_allow[s_axis_tid]) begin
            push         = 1'b1;
            beat_cnt_nxt = LEN_BITS'(1);
            // A zero limit also covers the filtering-disabled case.
            lim_nxt      = cfg_en ? cfg_max_beats : '0;
            if (s_axis_tlast) begin
              inc_fwd = 1'b1;
            end else if (cfg_en && cfg_max_beats == LEN_BITS'(1)) begin
              push_last = 1'b1;
              inc_fwd   = 1'b1;
              inc_trunc = 1'b1;
              state_nxt = DRAIN;
            end else begin
              state_nxt = PASS;
            end
          end else begin
            inc_drop = 1'b1;
            if (!s_axis_tlast) state_nxt = DROP;
          end
        end
      end
      PASS: begin
        if (s_fire) begin
          push = 1'b1;
          if (!(&beat_cnt)) beat_cnt_nxt = cnt_inc[LEN_BITS-1:0];
          if (s_axis_tlast) begin
            inc_fwd   = 1'b1;
            state_nxt = IDLE;
          end else if (lim_q != '0 && cnt_inc == {1'b0, lim_q}) begin
            push_last = 1'b1;
            inc_fwd   = 1'b1;
            inc_trunc = 1'b1;
            state_nxt = DRAIN;
          end
        end
      end
      DROP, DRAIN: begin
        if (s_fire && s_axis_tlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Skid buffer occupancy after this cycle's push/pop.
  always_comb begin
    buf_cnt_nxt = buf_cnt;
    case ({push, pop})
      2'b10:   buf_cnt_nxt = buf_cnt + 2'd1;
      2'b01:   buf_cnt_nxt = buf_cnt - 2'd1;
      default: buf_cnt_nxt = buf_cnt;
    endcase
  end

  // FSM, packet snapshot and skid buffer control registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state    <= IDLE;
      beat_cnt <= '0;
      lim_q    <= '0;
      buf_cnt  <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      lim_q    <= lim_nxt;
      buf_cnt  <= buf_cnt_nxt;
      rdy_q    <= (buf_cnt_nxt != 2'd2);
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  // Skid buffer storage; contents are don't-care while the entry is empty.
  always_ff @(posedge aclk) begin
    if (push) buf_mem[wr_ptr] <= {s_axis_tdata, s_axis_tkeep, s_axis_tid, push_last};
  end

  // Saturating packet statistics.
  always_ff @(posedge aclk) begin
    if (areset) begin
      stat_fwd_pkts   <= '0;
      stat_drop_pkts  <= '0;
      stat_trunc_pkts <= '0;
    end else begin
      if (inc_fwd   && !(&stat_fwd_pkts))   stat_fwd_pkts   <= stat_fwd_pkts + CNT_BITS'(1);
      if (inc_drop  && !(&stat_drop_pkts))  stat_drop_pkts  <= stat_drop_pkts + CNT_BITS'(1);
      if (inc_trunc && !(&stat_trunc_pkts)) stat_trunc_pkts <= stat_trunc_pkts + CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_axis_host_ingress_gate.sv
// Testbench for axis_host_ingress_gate: directed packets feed an expected-beat
// queue, an independent monitor pops and compares every egress beat.
module tb_axis_host_ingress_gate;
  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int TW = 6;
  localparam int LW = 16;
  localparam int CW = 32;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [TW-1:0] id;
    logic          l;
  } beat_t;

  logic          aclk, areset;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic [TW-1:0] s_axis_tid;
  logic          s_axis_tlast, s_axis_tvalid, s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [TW-1:0] m_axis_tid;
  logic          m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic          cfg_en;
  logic [2**TW-1:0] cfg_tid_allow;
  logic [LW-1:0] cfg_max_beats;
  logic [CW-1:0] stat_fwd_pkts, stat_drop_pkts, stat_trunc_pkts;
  logic          busy;

  axis_host_ingress_gate #(.DATA_BITS(DW), .TID_BITS(TW), .LEN_BITS(LW), .CNT_BITS(CW)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tid(s_axis_tid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tid(m_axis_tid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .cfg_en(cfg_en), .cfg_tid_allow(cfg_tid_allow), .cfg_max_beats(cfg_max_beats),
    .stat_fwd_pkts(stat_fwd_pkts), .stat_drop_pkts(stat_drop_pkts),
    .stat_trunc_pkts(stat_trunc_pkts), .busy(busy)
  );

  beat_t exp_q[$];
  int    out_cyc_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    out_cnt = 0;
  int    acc_cyc = 0;
  int    stall_cnt = 0;
  bit    rand_rdy = 0;
  bit    rdy_fixed = 1;
  beat_t cur;

  assign cur = {m_axis_tdata, m_axis_tkeep, m_axis_tid, m_axis_tlast};

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Egress back-pressure: fixed level or ~50% random, updated just after each edge.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_axis_tready = rand_rdy ? ($urandom_range(0, 1) == 1) : rdy_fixed;
    end
  end

  // Monitor: every transferred beat must match the head of the expected queue,
  // and a stalled beat must be held unchanged.
  initial begin
    beat_t held;
    beat_t e;
    bit    stalled;
    stalled = 0;
    held = '0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        stalled = 0;
      end else begin
        if (stalled) begin
          n_checks++;
          if (!m_axis_tvalid || cur !== held) begin
            n_fail++;
            $display("FAIL stall_hold: got valid=%0b %h required %h", m_axis_tvalid, cur, held);
          end
        end
        if (m_axis_tvalid && m_axis_tready) begin
          out_cnt++;
          out_cyc_q.push_back(cyc);
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_beat: got %h required no beat", cur);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              n_fail++;
              $display("FAIL egress_beat: got %h required %h", cur, e);
            end
          end
        end
        stalled = m_axis_tvalid && !m_axis_tready;
        held = cur;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Present one beat, queue its expected egress image, wait for acceptance.
  task automatic send_beat(input logic [TW-1:0] id, input logic last, input bit fwd, input bit fwd_last);
    beat_t b;
    beat_t e;
    bit    acc;
    int    waited;
    for (int i = 0; i < DW / 32; i++) b.d[i*32 +: 32] = $urandom();
    b.k = {$urandom(), $urandom()};
    b.id = id;
    b.l = last;
    s_axis_tdata = b.d;
    s_axis_tkeep = b.k;
    s_axis_tid = id;
    s_axis_tlast = last;
    s_axis_tvalid = 1'b1;
    if (fwd) begin
      e = b;
      e.l = fwd_last;
      exp_q.push_back(e);
    end
    acc = 0;
    waited = 0;
    while (!acc) begin
      @(negedge aclk);
      if (s_axis_tready) begin
        acc = 1;
        acc_cyc = cyc;
      end else begin
        stall_cnt++;
      end
      @(posedge aclk);
      #1;
      if (!acc) begin
        waited++;
        if (waited > 200) begin
          n_checks++;
          n_fail++;
          $display("FAIL ingress_accept_timeout: got no accept required accept within 200 cycles");
          break;
        end
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input logic [TW-1:0] id, input int n, input int nfwd);
    for (int i = 0; i < n; i++)
      send_beat(id, i == n - 1, i < nfwd, i == nfwd - 1);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (k < 1000) begin
      @(negedge aclk);
      if (exp_q.size() == 0 && !m_axis_tvalid) break;
      k++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    @(posedge aclk);
    #1;
  endtask

  initial begin
    int first_acc, snap, total, n;
    areset = 1'b1;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tid = '0;
    s_axis_tlast = 1'b0;
    s_axis_tvalid = 1'b0;
    cfg_en = 1'b1;
    cfg_tid_allow = '0;
    cfg_tid_allow[3] = 1'b1;
    cfg_max_beats = '0;
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    check("reset_m_tvalid", m_axis_tvalid, 0);
    check("reset_busy", busy, 0);
    check("reset_s_tready", s_axis_tready, 1);
    check("reset_stat_fwd", stat_fwd_pkts, 0);
    check("reset_stat_drop", stat_drop_pkts, 0);
    check("reset_stat_trunc", stat_trunc_pkts, 0);
    @(posedge aclk);
    #1;

    // 4-beat allowed packet, back-to-back with one cycle latency
    out_cyc_q.delete();
    send_beat(3, 0, 1, 0);
    first_acc = acc_cyc;
    send_beat(3, 0, 1, 0);
    send_beat(3, 0, 1, 0);
    send_beat(3, 1, 1, 1);
    wait_drain();
    check("t1_out_beats", out_cyc_q.size(), 4);
    check("t1_first_latency", out_cyc_q[0] - first_acc, 1);
    check("t1_back_to_back", out_cyc_q[3] - out_cyc_q[0], 3);
    check("t1_stat_fwd", stat_fwd_pkts, 1);

    // disallowed tid is swallowed without back-pressure
    stall_cnt = 0;
    snap = out_cnt;
    send_pkt(5, 3, 0);
    wait_drain();
    check("t2_no_stall", stall_cnt, 0);
    check("t2_no_output", out_cnt - snap, 0);
    check("t2_stat_drop", stat_drop_pkts, 1);
    check("t2_stat_fwd", stat_fwd_pkts, 1);

    // beat limit 2: 5-beat packet truncated, then 1-beat and exact-length packets
    cfg_max_beats = 16'd2;
    stall_cnt = 0;
    send_pkt(3, 5, 2);
    wait_drain();
    check("t3_drain_no_stall", stall_cnt, 0);
    check("t3_stat_trunc", stat_trunc_pkts, 1);
    check("t3_stat_fwd", stat_fwd_pkts, 2);
    send_pkt(3, 1, 1);
    send_pkt(3, 2, 2);
    wait_drain();
    check("t3_exact_limit_fwd", stat_fwd_pkts, 4);
    check("t3_exact_limit_trunc", stat_trunc_pkts, 1);
    cfg_max_beats = 16'd1;
    send_pkt(3, 3, 1);
    wait_drain();
    check("t3_limit1_fwd", stat_fwd_pkts, 5);
    check("t3_limit1_trunc", stat_trunc_pkts, 2);
    cfg_en = 1'b0;
    send_pkt(5, 3, 3);
    wait_drain();
    check("t3_disabled_fwd", stat_fwd_pkts, 6);
    check("t3_disabled_trunc", stat_trunc_pkts, 2);
    check("t3_disabled_drop", stat_drop_pkts, 1);

    // 100 packets under random egress back-pressure
    cfg_en = 1'b1;
    cfg_max_beats = '0;
    rand_rdy = 1;
    snap = out_cnt;
    total = 0;
    for (int p = 0; p < 100; p++) begin
      n = $urandom_range(1, 8);
      total += n;
      send_pkt(3, n, n);
    end
    rand_rdy = 0;
    rdy_fixed = 1;
    wait_drain();
    check("t4_beat_count", out_cnt - snap, total);
    check("t4_stat_fwd", stat_fwd_pkts, 106);

    // allow bit cleared mid-packet only affects the next packet
    send_beat(3, 0, 1, 0);
    send_beat(3, 0, 1, 0);
    cfg_tid_allow[3] = 1'b0;
    send_beat(3, 0, 1, 0);
    send_beat(3, 0, 1, 0);
    send_beat(3, 0, 1, 0);
    send_beat(3, 1, 1, 1);
    wait_drain();
    check("t5_stat_fwd", stat_fwd_pkts, 107);
    send_pkt(3, 3, 0);
    wait_drain();
    check("t5_stat_drop", stat_drop_pkts, 2);
    check("t5_stat_fwd_after", stat_fwd_pkts, 107);

    // reset in the middle of a stalled packet
    cfg_tid_allow[3] = 1'b1;
    rdy_fixed = 0;
    repeat (2) @(posedge aclk);
    #1;
    send_beat(3, 0, 1, 0);
    send_beat(3, 0, 1, 0);
    s_axis_tdata = '1;
    s_axis_tid = 6'd3;
    s_axis_tlast = 1'b0;
    s_axis_tvalid = 1'b1;
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    s_axis_tvalid = 1'b0;
    exp_q.delete();
    @(negedge aclk);
    check("t6_m_tvalid", m_axis_tvalid, 0);
    check("t6_busy", busy, 0);
    check("t6_stat_fwd", stat_fwd_pkts, 0);
    check("t6_stat_drop", stat_drop_pkts, 0);
    check("t6_stat_trunc", stat_trunc_pkts, 0);
    rdy_fixed = 1;
    repeat (2) @(posedge aclk);
    #1;
    snap = out_cnt;
    send_pkt(3, 3, 3);
    wait_drain();
    check("t6_post_reset_beats", out_cnt - snap, 3);
    check("t6_post_reset_fwd", stat_fwd_pkts, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
